// File: rtl/proteus_nfu2_accum_vn_if.sv
// Beat/result handshake bundle between NFU-1/NBout, the NFU-2 accumulator and NFU-3.
// The slave side is the accumulator; the master side drives beats and consumes results.
interface proteus_nfu2_accum_vn_if #(
    parameter int N   = 16,
    parameter int Tn  = 16,
    parameter int PW  = 8,
    parameter int OPW = 2
) ();
    logic                  i_valid;
    logic                  o_ready;
    logic [N*Tn*Tn-1:0]    i_prod;
    logic                  i_first;
    logic [PW-1:0]         i_npass;
    logic [OPW-1:0]        i_op;
    logic                  i_load_psum;
    logic [N*Tn-1:0]       i_psum;
    logic                  o_valid;
    logic                  i_ready;
    logic [N*Tn-1:0]       o_data;
    logic                  o_busy;

    modport slave (
        input  i_valid, i_prod, i_first, i_npass, i_op, i_load_psum, i_psum, i_ready,
        output o_ready, o_valid, o_data, o_busy
    );

    modport master (
        output i_valid, i_prod, i_first, i_npass, i_op, i_load_psum, i_psum, i_ready,
        input  o_ready, o_valid, o_data, o_busy
    );
endinterface

// File: rtl/proteus_nfu2_accum_vn.sv
// NFU-2 stage: per-lane registered reduce (SUM/MAX/MIN) then multi-pass accumulate,
// with a single result vector handed to NFU-3/NBout over valid/ready.
module proteus_nfu2_accum_vn_lane #(
    parameter int N   = 16,
    parameter int Tn  = 16,
    parameter int OPW = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_ld,
    input  logic [OPW-1:0]       i_op,
    input  logic [Tn-1:0][N-1:0] i_prod,
    input  logic                 i_upd,
    input  logic                 i_seed,
    input  logic                 i_load,
    input  logic [OPW-1:0]       i_s2_op,
    input  logic [N-1:0]         i_psum,
    output logic [N-1:0]         o_acc
);
    localparam int SW = N + $clog2(Tn);
    localparam logic signed [SW-1:0] SMAX = {{(SW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = {{(SW-N+1){1'b1}}, {(N-1){1'b0}}};
    localparam logic [N-1:0]   NMAX   = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]   NMIN   = {1'b1, {(N-1){1'b0}}};
    localparam logic [OPW-1:0] OP_MAX = OPW'(1);
    localparam logic [OPW-1:0] OP_MIN = OPW'(2);

    logic signed [SW-1:0] w_sum;
    logic [N-1:0]         w_red;
    logic [N-1:0]         w_ident;
    logic [N-1:0]         w_base;
    logic [N-1:0]         w_upd;
    logic [N:0]           w_asum;
    logic [N-1:0]         r_s1;
    logic [N-1:0]         r_acc;

    // Stage 1: full-width sum, clamped once at the end of the tree
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < Tn; k++) begin
            w_sum = w_sum + {{(SW-N){i_prod[k][N-1]}}, i_prod[k]};
        end
        w_red = i_prod[0];
        for (int k = 1; k < Tn; k++) begin
            if (i_op == OP_MAX && $signed(i_prod[k]) > $signed(w_red)) begin
                w_red = i_prod[k];
            end else if (i_op == OP_MIN && $signed(i_prod[k]) < $signed(w_red)) begin
                w_red = i_prod[k];
            end
        end
        if (i_op != OP_MAX && i_op != OP_MIN) begin
            if (w_sum > SMAX)      w_red = NMAX;
            else if (w_sum < SMIN) w_red = NMIN;
            else                   w_red = w_sum[N-1:0];
        end
    end

    // Stage 2: first beat of a group replaces the running value with its seed
    always_comb begin
        case (i_s2_op)
            OP_MAX:  w_ident = NMIN;
            OP_MIN:  w_ident = NMAX;
            default: w_ident = '0;
        endcase
        w_base = i_seed ? (i_load ? i_psum : w_ident) : r_acc;
        w_asum = {w_base[N-1], w_base} + {r_s1[N-1], r_s1};
        if (i_s2_op == OP_MAX) begin
            w_upd = ($signed(r_s1) > $signed(w_base)) ? r_s1 : w_base;
        end else if (i_s2_op == OP_MIN) begin
            w_upd = ($signed(r_s1) < $signed(w_base)) ? r_s1 : w_base;
        end else if (w_asum[N] != w_asum[N-1]) begin
            w_upd = w_asum[N] ? NMIN : NMAX;
        end else begin
            w_upd = w_asum[N-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1  <= '0;
            r_acc <= '0;
        end else begin
            if (i_ld)  r_s1  <= w_red;
            if (i_upd) r_acc <= w_upd;
        end
    end

    assign o_acc = r_acc;
endmodule

module proteus_nfu2_accum_vn #(
    parameter int N   = 16,
    parameter int Tn  = 16,
    parameter int PW  = 8,
    parameter int OPW = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    proteus_nfu2_accum_vn_if.slave      bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

    typedef struct packed {
        logic [OPW-1:0]       op;
        logic                 load;
        logic [Tn-1:0][N-1:0] psum;
    } grp_t;

    typedef struct packed {
        logic           vld;
        logic           first;
        logic           last;
        logic [OPW-1:0] op;
    } s1_t;

    state_t                       r_state, w_state_nx;
    grp_t                         r_grp;
    s1_t                          r_s1;
    logic [PW-1:0]                r_cnt;
    logic [PW-1:0]                w_cnt_cur;
    logic [Tn-1:0][Tn-1:0][N-1:0] w_prod;
    logic [Tn-1:0][N-1:0]         w_acc;
    logic                         w_accept;
    logic                         w_take;
    logic                         w_last;
    logic [OPW-1:0]               w_beat_op;

    assign w_prod      = bus.i_prod;
    // Hold off new beats from the last beat's accept until the result is consumed
    assign bus.o_ready = (r_state != S_OUT) && !(r_s1.vld && r_s1.last);
    assign w_accept    = bus.i_valid && bus.o_ready;
    // Non-first beats outside a group are dropped; a first beat in ACC restarts
    assign w_take      = w_accept && (bus.i_first || r_state == S_ACC);
    assign w_beat_op   = bus.i_first ? bus.i_op : r_grp.op;
    assign w_cnt_cur   = bus.i_first ? ((bus.i_npass > PW'(1)) ? bus.i_npass - PW'(1) : '0)
                                     : r_cnt;
    assign w_last      = (w_cnt_cur == '0);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: if (w_take)                w_state_nx = S_ACC;
            S_ACC:  if (r_s1.vld && r_s1.last) w_state_nx = S_OUT;
            S_OUT:  if (bus.i_ready)           w_state_nx = S_IDLE;
            default:                           w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grp   <= '0;
            r_s1    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_s1    <= '{vld: w_take, first: bus.i_first, last: w_last, op: w_beat_op};
            if (w_take) begin
                r_cnt <= w_last ? '0 : w_cnt_cur - PW'(1);
            end
            if (w_take && bus.i_first) begin
                r_grp <= '{op: bus.i_op, load: bus.i_load_psum, psum: bus.i_psum};
            end
        end
    end

    for (genvar j = 0; j < Tn; j++) begin : g_lane
        proteus_nfu2_accum_vn_lane #(.N(N), .Tn(Tn), .OPW(OPW)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_ld    (w_take),
            .i_op    (w_beat_op),
            .i_prod  (w_prod[j]),
            .i_upd   (r_s1.vld),
            .i_seed  (r_s1.first),
            .i_load  (r_grp.load),
            .i_s2_op (r_s1.op),
            .i_psum  (r_grp.psum[j]),
            .o_acc   (w_acc[j])
        );
    end

    assign bus.o_valid = (r_state == S_OUT);
    assign bus.o_data  = w_acc;
    assign bus.o_busy  = (r_state != S_IDLE) || r_s1.vld;
endmodule

// File: tb/tb_proteus_nfu2_accum_vn.sv
// Directed bench for the NFU-2 accumulator at N=16, Tn=4 with cycle-exact expectations.
module tb_proteus_nfu2_accum_vn;
    localparam int N = 16, TN = 4, PW = 8, OPW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;
    logic [255:0] pv;

    proteus_nfu2_accum_vn_if #(.N(N), .Tn(TN), .PW(PW), .OPW(OPW)) bus ();

    proteus_nfu2_accum_vn #(.N(N), .Tn(TN), .PW(PW), .OPW(OPW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rep(input logic [15:0] a, b, c, d);
        return {4{d, c, b, a}};
    endfunction

    function automatic logic [63:0] r4(input logic [15:0] v);
        return {4{v}};
    endfunction

    // Drive one beat from a negedge; returns at the next negedge with valid dropped
    task automatic send(input bit first, input int np, input int op, input bit ld,
                        input logic [15:0] ps, input logic [255:0] prod);
        bus.i_valid     = 1'b1;
        bus.i_first     = first;
        bus.i_npass     = PW'(np);
        bus.i_op        = OPW'(op);
        bus.i_load_psum = ld;
        bus.i_psum      = r4(ps);
        bus.i_prod      = prod;
        @(negedge clk);
        // junk group parameters between beats must not matter
        bus.i_valid     = 1'b0;
        bus.i_first     = 1'b0;
        bus.i_npass     = 8'd7;
        bus.i_op        = 2'd2;
        bus.i_load_psum = 1'b1;
        bus.i_psum      = r4(16'h1234);
    endtask

    // Called one cycle after the last beat; consumes the result with i_ready=1
    task automatic expect_result(input string tag, input logic [63:0] exp);
        chk({tag, "_early"}, {63'd0, bus.o_valid}, 64'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {63'd0, bus.o_valid}, 64'd1);
        chk({tag, "_data"}, bus.o_data, exp);
        @(negedge clk);
        chk({tag, "_done"}, {63'd0, bus.o_valid}, 64'd0);
    endtask

    initial begin
        bus.i_valid = 1'b0; bus.i_first = 1'b0; bus.i_npass = '0; bus.i_op = '0;
        bus.i_load_psum = 1'b0; bus.i_psum = '0; bus.i_prod = '0; bus.i_ready = 1'b1;

        @(negedge clk); @(negedge clk);
        chk("rst_valid", {63'd0, bus.o_valid}, 64'd0);
        chk("rst_data", bus.o_data, 64'd0);
        chk("rst_busy", {63'd0, bus.o_busy}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {63'd0, bus.o_ready}, 64'd1);

        // SUM npass=1, all ones
        send(1, 1, 0, 0, 16'd0, rep(16'd1, 16'd1, 16'd1, 16'd1));
        chk("t1_ready_low", {63'd0, bus.o_ready}, 64'd0);
        expect_result("t1", r4(16'd4));
        chk("t1_idle_busy", {63'd0, bus.o_busy}, 64'd0);
        chk("t1_idle_ready", {63'd0, bus.o_ready}, 64'd1);

        // SUM npass=3 with psum -50, then backpressure for 5 cycles
        send(1, 3, 0, 1, 16'hFFCE, rep(16'd100, 16'd100, 16'd100, 16'd100));
        chk("t2_ready_mid", {63'd0, bus.o_ready}, 64'd1);
        send(0, 0, 0, 0, 16'd0, rep(16'd100, 16'd100, 16'd100, 16'd100));
        bus.i_ready = 1'b0;
        send(0, 0, 0, 0, 16'd0, rep(16'd100, 16'd100, 16'd100, 16'd100));
        chk("t2_ready_last", {63'd0, bus.o_ready}, 64'd0);
        chk("t2_early", {63'd0, bus.o_valid}, 64'd0);
        @(negedge clk);
        chk("t2_valid", {63'd0, bus.o_valid}, 64'd1);
        chk("t2_data", bus.o_data, r4(16'h047E));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {63'd0, bus.o_valid}, 64'd1);
            chk("bp_data", bus.o_data, r4(16'h047E));
            chk("bp_ready", {63'd0, bus.o_ready}, 64'd0);
            chk("bp_busy", {63'd0, bus.o_busy}, 64'd1);
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {63'd0, bus.o_valid}, 64'd0);
        chk("bp_release_ready", {63'd0, bus.o_ready}, 64'd1);

        // Saturation, first beat right after the handshake
        send(1, 1, 0, 0, 16'd0, rep(16'h7000, 16'h7000, 16'h7000, 16'h7000));
        expect_result("sat_pos", r4(16'h7FFF));
        send(1, 1, 0, 0, 16'd0, rep(16'h8000, 16'h8000, 16'h8000, 16'h8000));
        expect_result("sat_neg", r4(16'h8000));
        send(1, 2, 0, 0, 16'd0, rep(16'h2000, 16'h2000, 16'h2000, 16'h2000));
        send(0, 0, 0, 0, 16'd0, rep(16'h2000, 16'h2000, 16'h2000, 16'h2000));
        expect_result("sat_acc", r4(16'h7FFF));

        // MAX / MIN over two beats
        send(1, 2, 1, 0, 16'd0, rep(16'hFFFB, 16'd3, 16'd9, 16'hFFFF));
        send(0, 0, 0, 0, 16'd0, rep(16'd2, 16'd8, 16'd7, 16'd0));
        expect_result("max", r4(16'd9));
        send(1, 2, 2, 0, 16'd0, rep(16'hFFFB, 16'd3, 16'd9, 16'hFFFF));
        send(0, 0, 0, 0, 16'd0, rep(16'd2, 16'd8, 16'd7, 16'd0));
        expect_result("min", r4(16'hFFFB));
        send(1, 2, 1, 1, 16'd20, rep(16'hFFFB, 16'd3, 16'd9, 16'hFFFF));
        send(0, 0, 0, 0, 16'd0, rep(16'd2, 16'd8, 16'd7, 16'd0));
        expect_result("max_psum", r4(16'd20));
        send(1, 2, 2, 1, 16'hFF9C, rep(16'hFFFB, 16'd3, 16'd9, 16'hFFFF));
        send(0, 0, 0, 0, 16'd0, rep(16'd2, 16'd8, 16'd7, 16'd0));
        expect_result("min_psum", r4(16'hFF9C));

        // op=3 is SUM; npass=0 behaves as 1
        send(1, 0, 3, 0, 16'd0, rep(16'd1, 16'd2, 16'd3, 16'd4));
        expect_result("op3_np0", r4(16'd10));

        // Distinct per-lane products
        for (int j = 0; j < TN; j++)
            for (int k = 0; k < TN; k++)
                pv[(j*TN+k)*N +: N] = 16'(j + 1);
        send(1, 1, 0, 0, 16'd0, pv);
        expect_result("lanes", {16'd16, 16'd12, 16'd8, 16'd4});

        // Non-first beat in IDLE is dropped
        send(0, 1, 0, 0, 16'd0, rep(16'd5, 16'd5, 16'd5, 16'd5));
        chk("drop_busy", {63'd0, bus.o_busy}, 64'd0);
        @(negedge clk);
        chk("drop_valid", {63'd0, bus.o_valid}, 64'd0);

        // Bubbles mid-group
        send(1, 2, 0, 0, 16'd0, rep(16'd1, 16'd1, 16'd1, 16'd1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bubble_valid", {63'd0, bus.o_valid}, 64'd0);
            chk("bubble_busy", {63'd0, bus.o_busy}, 64'd1);
        end
        send(0, 0, 0, 0, 16'd0, rep(16'd1, 16'd1, 16'd1, 16'd1));
        expect_result("bubble", r4(16'd8));

        // Abort: new first beat mid-group restarts with new parameters
        send(1, 3, 0, 0, 16'd0, rep(16'd1, 16'd1, 16'd1, 16'd1));
        chk("abort_v0", {63'd0, bus.o_valid}, 64'd0);
        send(0, 0, 0, 0, 16'd0, rep(16'd1, 16'd1, 16'd1, 16'd1));
        chk("abort_v1", {63'd0, bus.o_valid}, 64'd0);
        send(1, 1, 1, 0, 16'd0, rep(16'd5, 16'd6, 16'd7, 16'd8));
        expect_result("abort", r4(16'd8));

        // Async reset mid-group
        send(1, 3, 0, 0, 16'd0, rep(16'd1, 16'd1, 16'd1, 16'd1));
        send(0, 0, 0, 0, 16'd0, rep(16'd1, 16'd1, 16'd1, 16'd1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, bus.o_valid}, 64'd0);
        chk("arst_data", bus.o_data, 64'd0);
        chk("arst_busy", {63'd0, bus.o_busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready", {63'd0, bus.o_ready}, 64'd1);
        send(1, 1, 0, 0, 16'd0, rep(16'd2, 16'd2, 16'd2, 16'd2));
        expect_result("post_rst", r4(16'd8));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
